// File: rtl/muxn_req_l2.sv
// ---------------------------------------------------------------------------
// muxn_req_l2 -- N-channel round-robin request arbiter/mux for an L2 bank port
//
// Fair rotating-pointer arbitration over N_CH masters. The winning channel's
// request payload is forwarded to a single L2 bank.
//
// Build option (macro MUXN_REQ_L2_OUT_REG_EN):
//   undefined : combinational pass-through, 0-cycle latency
//   defined   : one-deep output register slice, 1-cycle latency. This breaks
//               the req->gnt path through the bank.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   data_req_i        per-channel request             [N_CH]
//   data_add_i        per-channel address             [N_CH][ADDR_WIDTH]
//   data_wen_i        per-channel write-enable-n      [N_CH] (1 = read)
//   data_wdata_i      per-channel write data          [N_CH][DATA_WIDTH]
//   data_be_i         per-channel byte enables        [N_CH][BE_WIDTH]
//   data_ID_i         per-channel transaction ID      [N_CH][ID_WIDTH]
//   data_gnt_o        per-channel grant, one-hot or zero
//   data_req_o        request to bank
//   data_*_o          forwarded payload
//   data_gnt_i        bank grant
// ---------------------------------------------------------------------------
module muxn_req_l2 #(
    parameter int N_CH       = 4,
    parameter int ID_WIDTH   = 20,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [N_CH-1:0]                      data_req_i,
    input  logic [N_CH-1:0][ADDR_WIDTH-1:0]      data_add_i,
    input  logic [N_CH-1:0]                      data_wen_i,
    input  logic [N_CH-1:0][DATA_WIDTH-1:0]      data_wdata_i,
    input  logic [N_CH-1:0][BE_WIDTH-1:0]        data_be_i,
    input  logic [N_CH-1:0][ID_WIDTH-1:0]        data_ID_i,
    output logic [N_CH-1:0]                      data_gnt_o,
    output logic                                 data_req_o,
    output logic [ADDR_WIDTH-1:0]                data_add_o,
    output logic                                 data_wen_o,
    output logic [DATA_WIDTH-1:0]                data_wdata_o,
    output logic [BE_WIDTH-1:0]                  data_be_o,
    output logic [ID_WIDTH-1:0]                  data_ID_o,
    input  logic                                 data_gnt_i
);

    localparam int LOG_CH = $clog2(N_CH);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] add;
        logic                  wen;
        logic [DATA_WIDTH-1:0] wdata;
        logic [BE_WIDTH-1:0]   be;
        logic [ID_WIDTH-1:0]   id;
    } payload_t;

    logic [LOG_CH-1:0] rr_ptr_q, rr_ptr_d;
    logic [LOG_CH-1:0] winner;
    logic [LOG_CH-1:0] cand;
    logic              found;
    logic              any_req;
    logic              gnt_en;     // input-side handshake for the winner
    payload_t          win_pl;

    assign any_req = |data_req_i;

    // Search starts one past the last granted channel and wraps. The modulo is
    // done on an int, so a non-power-of-2 N_CH never yields an index >= N_CH.
    // With nothing pending, the winner falls back to CH0.
    always_comb begin
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        for (int k = 1; k <= N_CH; k++) begin
            cand = LOG_CH'((int'(rr_ptr_q) + k) % N_CH);
            if (!found && data_req_i[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        win_pl.add   = data_add_i[winner];
        win_pl.wen   = data_wen_i[winner];
        win_pl.wdata = data_wdata_i[winner];
        win_pl.be    = data_be_i[winner];
        win_pl.id    = data_ID_i[winner];
    end

`ifdef MUXN_REQ_L2_OUT_REG_EN
    logic     valid_q, valid_d;
    payload_t payload_q, payload_d;

    // Accept into the slice when it is empty or draining this cycle. Grants
    // are suppressed while in reset, because the slice is being cleared.
    assign gnt_en = any_req & (~valid_q | data_gnt_i) & ~rst;

    always_comb begin
        valid_d   = valid_q;
        payload_d = payload_q;
        if (gnt_en) begin
            payload_d = win_pl;
            valid_d   = 1'b1;
        end else if (data_gnt_i) begin
            valid_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
        end else begin
            valid_q   <= valid_d;
            payload_q <= payload_d;
        end
    end

    assign data_req_o   = valid_q;
    assign data_add_o   = payload_q.add;
    assign data_wen_o   = payload_q.wen;
    assign data_wdata_o = payload_q.wdata;
    assign data_be_o    = payload_q.be;
    assign data_ID_o    = payload_q.id;
`else
    assign gnt_en       = any_req & data_gnt_i & ~rst;

    assign data_req_o   = any_req;
    assign data_add_o   = win_pl.add;
    assign data_wen_o   = win_pl.wen;
    assign data_wdata_o = win_pl.wdata;
    assign data_be_o    = win_pl.be;
    assign data_ID_o    = win_pl.id;
`endif

    assign data_gnt_o = gnt_en ? (N_CH'(1) << winner) : '0;

    // After a grant, the granted channel drops to lowest priority.
    assign rr_ptr_d = gnt_en ? winner : rr_ptr_q;

    always_ff @(posedge clk) begin
        if (rst) rr_ptr_q <= LOG_CH'(N_CH - 1);
        else     rr_ptr_q <= rr_ptr_d;
    end

endmodule

// File: tb/tb_muxn_req_l2.sv
module tb_muxn_req_l2;
    localparam int N = 4, AW = 32, DW = 64, BW = 8, IW = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]          req_i = '0, wen_i = '0, gnt_o;
    logic [N-1:0][AW-1:0]  add_i;
    logic [N-1:0][DW-1:0]  wdata_i;
    logic [N-1:0][BW-1:0]  be_i;
    logic [N-1:0][IW-1:0]  id_i;
    logic                  gnt_i = 1'b0, req_o, wen_o;
    logic [AW-1:0]         add_o;
    logic [DW-1:0]         wdata_o;
    logic [BW-1:0]         be_o;
    logic [IW-1:0]         id_o;

    logic [2:0]            req3_i = '0, wen3_i = '0, gnt3_o;
    logic [2:0][AW-1:0]    add3_i;
    logic [2:0][DW-1:0]    wdata3_i;
    logic [2:0][BW-1:0]    be3_i;
    logic [2:0][IW-1:0]    id3_i;
    logic                  gnt3_i = 1'b0, req3_o, wen3_o;
    logic [AW-1:0]         add3_o;
    logic [DW-1:0]         wdata3_o;
    logic [BW-1:0]         be3_o;
    logic [IW-1:0]         id3_o;

    int errs = 0, checks = 0;

    muxn_req_l2 #(.N_CH(4)) dut (
        .clk(clk), .rst(rst),
        .data_req_i(req_i), .data_add_i(add_i), .data_wen_i(wen_i),
        .data_wdata_i(wdata_i), .data_be_i(be_i), .data_ID_i(id_i),
        .data_gnt_o(gnt_o), .data_req_o(req_o), .data_add_o(add_o),
        .data_wen_o(wen_o), .data_wdata_o(wdata_o), .data_be_o(be_o),
        .data_ID_o(id_o), .data_gnt_i(gnt_i)
    );

    muxn_req_l2 #(.N_CH(3)) dut3 (
        .clk(clk), .rst(rst),
        .data_req_i(req3_i), .data_add_i(add3_i), .data_wen_i(wen3_i),
        .data_wdata_i(wdata3_i), .data_be_i(be3_i), .data_ID_i(id3_i),
        .data_gnt_o(gnt3_o), .data_req_o(req3_o), .data_add_o(add3_o),
        .data_wen_o(wen3_o), .data_wdata_o(wdata3_o), .data_be_o(be3_o),
        .data_ID_o(id3_o), .data_gnt_i(gnt3_i)
    );

    function automatic logic [AW-1:0] exp_add(int ch);
        return 32'h0000_1000 + 32'(ch * 16);
    endfunction
    function automatic logic [DW-1:0] exp_wd(int ch);
        return {32'hDA7A_0000 + 32'(ch), 32'h5A5A_0000 + 32'(ch)};
    endfunction
    function automatic logic [BW-1:0] exp_be(int ch);
        return 8'(8'h11 << ch);
    endfunction
    function automatic logic [IW-1:0] exp_id(int ch);
        return 20'(20'h000A0 + ch);
    endfunction

    // advance one clock; inputs are driven 2 time units after the edge
    task automatic cyc;
        @(posedge clk);
        #2;
    endtask

    task automatic load_tables;
        for (int ch = 0; ch < N; ch++) begin
            add_i[ch] = exp_add(ch); wdata_i[ch] = exp_wd(ch);
            be_i[ch] = exp_be(ch);   id_i[ch] = exp_id(ch);
            wen_i[ch] = ch[0];
        end
        for (int ch = 0; ch < 3; ch++) begin
            add3_i[ch] = exp_add(ch); wdata3_i[ch] = exp_wd(ch);
            be3_i[ch] = exp_be(ch);   id3_i[ch] = exp_id(ch);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; req_i = 4'b0001; gnt_i = 1'b1;
        cyc; cyc; #1;
        checks++; if (gnt_o !== 4'b0000) begin errs++; $display("FAIL rst_gnt got=%b exp=0000", gnt_o); end
`ifdef MUXN_REQ_L2_OUT_REG_EN
        checks++; if (req_o !== 1'b0) begin errs++; $display("FAIL rst_req got=%b exp=0", req_o); end
        checks++; if (add_o !== '0 || id_o !== '0 || wdata_o !== '0 || be_o !== '0 || wen_o !== 1'b0) begin
            errs++; $display("FAIL rst_payload add=%h id=%h wd=%h be=%h exp=0", add_o, id_o, wdata_o, be_o); end
`else
        checks++; if (req_o !== 1'b1) begin errs++; $display("FAIL rst_req got=%b exp=1", req_o); end
        checks++; if (add_o !== exp_add(0)) begin errs++; $display("FAIL rst_add got=%h exp=%h", add_o, exp_add(0)); end
`endif
        rst = 1'b0; req_i = '0; gnt_i = 1'b0;
        cyc;
    endtask

    task automatic test_idle;
        req_i = '0; gnt_i = 1'b1; #1;
        checks++; if (gnt_o !== 4'b0000) begin errs++; $display("FAIL idle_gnt got=%b exp=0000", gnt_o); end
        checks++; if (req_o !== 1'b0) begin errs++; $display("FAIL idle_req got=%b exp=0", req_o); end
`ifndef MUXN_REQ_L2_OUT_REG_EN
        checks++; if (add_o !== exp_add(0)) begin errs++; $display("FAIL idle_add got=%h exp=%h", add_o, exp_add(0)); end
`endif
        cyc;
    endtask

    task automatic test_all_req;
        int ch, pv;
        req_i = 4'b1111; gnt_i = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            ch = c % 4; pv = (c + 3) % 4;
            checks++; if (gnt_o !== 4'(1 << ch)) begin errs++; $display("FAIL all_gnt c=%0d got=%b exp=%b", c, gnt_o, 4'(1 << ch)); end
`ifdef MUXN_REQ_L2_OUT_REG_EN
            checks++; if (req_o !== (c != 0)) begin errs++; $display("FAIL all_req c=%0d got=%b", c, req_o); end
            if (c != 0) begin
                checks++;
                if (add_o !== exp_add(pv) || wdata_o !== exp_wd(pv) || be_o !== exp_be(pv) || id_o !== exp_id(pv) || wen_o !== pv[0]) begin
                    errs++; $display("FAIL all_payload c=%0d add=%h id=%h exp_add=%h exp_id=%h", c, add_o, id_o, exp_add(pv), exp_id(pv)); end
            end
`else
            checks++;
            if (add_o !== exp_add(ch) || wdata_o !== exp_wd(ch) || be_o !== exp_be(ch) || id_o !== exp_id(ch) || wen_o !== ch[0]) begin
                errs++; $display("FAIL all_payload c=%0d add=%h id=%h exp_add=%h exp_id=%h", c, add_o, id_o, exp_add(ch), exp_id(ch)); end
`endif
            cyc;
        end
    endtask

    task automatic test_alternate;
        int ch, pv;
        req_i = 4'b1010; gnt_i = 1'b1; pv = 3;
        for (int c = 0; c < 4; c++) begin
            #1;
            ch = (c % 2 == 0) ? 1 : 3;
            checks++; if (gnt_o !== 4'(1 << ch)) begin errs++; $display("FAIL alt_gnt c=%0d got=%b exp=%b", c, gnt_o, 4'(1 << ch)); end
`ifdef MUXN_REQ_L2_OUT_REG_EN
            checks++; if (add_o !== exp_add(pv)) begin errs++; $display("FAIL alt_add c=%0d got=%h exp=%h", c, add_o, exp_add(pv)); end
`else
            checks++; if (add_o !== exp_add(ch)) begin errs++; $display("FAIL alt_add c=%0d got=%h exp=%h", c, add_o, exp_add(ch)); end
`endif
            pv = ch;
            cyc;
        end
    endtask

    task automatic test_stall;
        req_i = 4'b0100; gnt_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (gnt_o !== 4'b0000) begin errs++; $display("FAIL stall_gnt c=%0d got=%b exp=0000", c, gnt_o); end
            checks++; if (req_o !== 1'b1) begin errs++; $display("FAIL stall_req c=%0d got=%b exp=1", c, req_o); end
`ifdef MUXN_REQ_L2_OUT_REG_EN
            checks++; if (add_o !== exp_add(3)) begin errs++; $display("FAIL stall_hold c=%0d got=%h exp=%h", c, add_o, exp_add(3)); end
`else
            checks++; if (add_o !== exp_add(2)) begin errs++; $display("FAIL stall_add c=%0d got=%h exp=%h", c, add_o, exp_add(2)); end
`endif
            cyc;
        end
        gnt_i = 1'b1; #1;
        checks++; if (gnt_o !== 4'b0100) begin errs++; $display("FAIL stall_rel_gnt got=%b exp=0100", gnt_o); end
        cyc;
        req_i = '0; gnt_i = 1'b0; #1;
`ifdef MUXN_REQ_L2_OUT_REG_EN
        checks++; if (req_o !== 1'b1 || add_o !== exp_add(2)) begin errs++; $display("FAIL stall_out req=%b add=%h exp=1/%h", req_o, add_o, exp_add(2)); end
`else
        checks++; if (req_o !== 1'b0 || gnt_o !== 4'b0000) begin errs++; $display("FAIL stall_out req=%b gnt=%b exp=0/0000", req_o, gnt_o); end
`endif
        cyc;
    endtask

    task automatic test_slice;
        rst = 1'b1; req_i = '0; gnt_i = 1'b0;
        cyc;
        rst = 1'b0; add_i[1] = 32'h100; req_i = 4'b0010; #1;
`ifdef MUXN_REQ_L2_OUT_REG_EN
        checks++; if (gnt_o !== 4'b0010 || req_o !== 1'b0) begin errs++; $display("FAIL slice_c0 gnt=%b req=%b exp=0010/0", gnt_o, req_o); end
        cyc;
        req_i = 4'b0100;
        for (int c = 1; c < 3; c++) begin
            #1;
            checks++; if (gnt_o !== 4'b0000) begin errs++; $display("FAIL slice_gnt c=%0d got=%b exp=0000", c, gnt_o); end
            checks++; if (req_o !== 1'b1 || add_o !== 32'h100) begin errs++; $display("FAIL slice_hold c=%0d req=%b add=%h exp=1/100", c, req_o, add_o); end
            cyc;
        end
        gnt_i = 1'b1; #1;
        checks++; if (gnt_o !== 4'b0100 || add_o !== 32'h100) begin errs++; $display("FAIL slice_drain gnt=%b add=%h exp=0100/100", gnt_o, add_o); end
        cyc;
        req_i = '0; gnt_i = 1'b0; #1;
        checks++; if (req_o !== 1'b1 || add_o !== exp_add(2)) begin errs++; $display("FAIL slice_next req=%b add=%h exp=1/%h", req_o, add_o, exp_add(2)); end
`else
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (gnt_o !== 4'b0000) begin errs++; $display("FAIL slice_gnt c=%0d got=%b exp=0000", c, gnt_o); end
            checks++; if (req_o !== 1'b1 || add_o !== 32'h100) begin errs++; $display("FAIL slice_pass c=%0d req=%b add=%h exp=1/100", c, req_o, add_o); end
            cyc;
        end
        gnt_i = 1'b1; #1;
        checks++; if (gnt_o !== 4'b0010) begin errs++; $display("FAIL slice_rel_gnt got=%b exp=0010", gnt_o); end
        cyc;
        req_i = '0; gnt_i = 1'b0;
`endif
        add_i[1] = exp_add(1);
        cyc;
    endtask

    task automatic test_n3;
        req3_i = 3'b111; gnt3_i = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            checks++; if (gnt3_o !== 3'(1 << (c % 3))) begin errs++; $display("FAIL n3_gnt c=%0d got=%b exp=%b", c, gnt3_o, 3'(1 << (c % 3))); end
`ifndef MUXN_REQ_L2_OUT_REG_EN
            checks++; if (add3_o !== exp_add(c % 3)) begin errs++; $display("FAIL n3_add c=%0d got=%h exp=%h", c, add3_o, exp_add(c % 3)); end
`endif
            cyc;
        end
        req3_i = '0; gnt3_i = 1'b0;
        cyc;
    endtask

    task automatic test_reset_mid;
        int first;
`ifdef MUXN_REQ_L2_OUT_REG_EN
        first = 3;   // last grant before this test was CH2
`else
        first = 2;   // last grant before this test was CH1
`endif
        req_i = 4'b1111; gnt_i = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++; if (gnt_o !== 4'(1 << ((first + c) % 4))) begin errs++; $display("FAIL mid_gnt c=%0d got=%b exp=%b", c, gnt_o, 4'(1 << ((first + c) % 4))); end
            cyc;
        end
        rst = 1'b1; #1;
        checks++; if (gnt_o !== 4'b0000) begin errs++; $display("FAIL mid_rst_gnt0 got=%b exp=0000", gnt_o); end
        cyc; #1;
        checks++; if (gnt_o !== 4'b0000) begin errs++; $display("FAIL mid_rst_gnt1 got=%b exp=0000", gnt_o); end
`ifdef MUXN_REQ_L2_OUT_REG_EN
        checks++; if (req_o !== 1'b0 || add_o !== '0 || wdata_o !== '0) begin errs++; $display("FAIL mid_rst_out req=%b add=%h exp=0/0", req_o, add_o); end
`else
        checks++; if (req_o !== 1'b1) begin errs++; $display("FAIL mid_rst_req got=%b exp=1", req_o); end
`endif
        rst = 1'b0; req_i = 4'b1100; #1;
        checks++; if (gnt_o !== 4'b0100) begin errs++; $display("FAIL mid_after_gnt got=%b exp=0100", gnt_o); end
        cyc; #1;
        checks++; if (gnt_o !== 4'b1000) begin errs++; $display("FAIL mid_after_gnt2 got=%b exp=1000", gnt_o); end
`ifdef MUXN_REQ_L2_OUT_REG_EN
        checks++; if (req_o !== 1'b1 || add_o !== exp_add(2)) begin errs++; $display("FAIL mid_after_add req=%b add=%h exp=1/%h", req_o, add_o, exp_add(2)); end
`else
        checks++; if (add_o !== exp_add(3)) begin errs++; $display("FAIL mid_after_add got=%h exp=%h", add_o, exp_add(3)); end
`endif
        req_i = '0; gnt_i = 1'b0;
        cyc;
    endtask

    initial begin
        load_tables();
        #2;
        test_reset();
        test_idle();
        test_all_req();
        test_alternate();
        test_stall();
        test_slice();
        test_n3();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
